// File: rtl/core_pkg.sv
// Types and constants shared by the core front end: fetch FSM states,
// the buffered fetch entry layout and the default reset fetch address.
package core_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    KILL = 2'd2
  } fetch_state_t;

  localparam int CORE_XLEN = 32;

  localparam logic [CORE_XLEN-1:0] DEFAULT_RESET_PC = '0;

  // Buffered instruction tagged with the address it was fetched from.
  typedef struct packed {
    logic [CORE_XLEN-1:0] pc;
    logic [CORE_XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Signal bundle of the fetch unit: instruction cache request/response,
// redirect strobe, decode-side valid/ready port and debug visibility.
interface fetch_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) ();
  import core_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  // Cache side: inst_req/inst_addr hold steady until the single-cycle
  // inst_valid strobe; inst_valid with inst_req low carries no meaning.
  // Decode side: an entry transfers on every edge where out_valid and
  // out_ready are both high; out_inst/out_pc are stable while out_valid
  // waits for out_ready (unless a redirect flushes the buffer).
  logic                  inst_req;
  logic [DATA_WIDTH-1:0] inst_addr;
  logic                  inst_valid;
  logic [DATA_WIDTH-1:0] inst_data;
  logic                  redirect;
  logic [DATA_WIDTH-1:0] redirect_pc;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_inst;
  logic [DATA_WIDTH-1:0] out_pc;
  logic [CW-1:0]         fifo_count;
  fetch_state_t          state;

  modport master (
    output inst_req, inst_addr, out_valid, out_inst, out_pc, fifo_count, state,
    input  inst_valid, inst_data, redirect, redirect_pc, out_ready
  );

  modport slave (
    input  inst_req, inst_addr, out_valid, out_inst, out_pc, fifo_count, state,
    output inst_valid, inst_data, redirect, redirect_pc, out_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of {pc, inst} fetch entries with flush and occupancy.
// Flush wins over push and pop in the same cycle.
module fetch_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 push,
  input  logic                                 pop,
  input  logic                                 flush,
  input  logic [DATA_WIDTH-1:0]                push_pc,
  input  logic [DATA_WIDTH-1:0]                push_inst,
  output logic                                 out_valid,
  output logic [DATA_WIDTH-1:0]                out_pc,
  output logic [DATA_WIDTH-1:0]                out_inst,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]      count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] inst;
  } entry_t;

  entry_t        mem [FIFO_DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  // A full FIFO still accepts a push when a pop frees the head slot.
  assign do_pop  = pop && !flush && (count != '0);
  assign do_push = push && !flush && ((count != CW'(FIFO_DEPTH)) || do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= '{pc: push_pc, inst: push_inst};
        wptr      <= wptr + PW'(1);
      end
      if (do_pop) begin
        rptr <= rptr + PW'(1);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  assign out_valid = (count != '0);
  assign out_pc    = mem[rptr].pc;
  assign out_inst  = mem[rptr].inst;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: sequential PC generation, single outstanding
// cache request, buffered {pc, inst} delivery to decode and redirect flush.
module fetch_unit
  import core_pkg::*;
#(
  parameter int                    DATA_WIDTH      = 32,
  parameter int                    BYTE_DATA_WIDTH = 4,
  parameter int                    FIFO_DEPTH      = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_PC        = DATA_WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  fetch_state_t          state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] pc_step;
  logic                  push;
  logic                  pop;
  logic [CW:0]           occ_next;
  logic                  space;

  assign push    = (state_q == REQ) && bus.inst_valid && !bus.redirect;
  assign pop     = bus.out_valid && bus.out_ready && !bus.redirect;
  assign pc_step = pc_q + DATA_WIDTH'(BYTE_DATA_WIDTH);

  // Occupancy after this edge; a request is only issued when the slot its
  // response will need is guaranteed to be free.
  always_comb begin
    occ_next = '0;
    if (!bus.redirect) begin
      occ_next = {1'b0, bus.fifo_count} + (CW+1)'(push) - (CW+1)'(pop);
    end
  end

  assign space = occ_next < (CW+1)'(FIFO_DEPTH);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        if (bus.redirect) begin
          pc_d = bus.redirect_pc;
          if (space) begin
            state_d = REQ;
            addr_d  = bus.redirect_pc;
          end
        end else if (space) begin
          state_d = REQ;
          addr_d  = pc_q;
        end
      end
      REQ: begin
        if (bus.redirect && bus.inst_valid) begin
          pc_d   = bus.redirect_pc;
          addr_d = bus.redirect_pc;
        end else if (bus.redirect) begin
          // The old request is still owed a response; wait for it in KILL.
          pc_d    = bus.redirect_pc;
          state_d = KILL;
        end else if (bus.inst_valid) begin
          pc_d = pc_step;
          if (space) begin
            addr_d = pc_step;
          end else begin
            state_d = IDLE;
          end
        end
      end
      KILL: begin
        if (bus.redirect) begin
          pc_d = bus.redirect_pc;
          if (bus.inst_valid) begin
            state_d = REQ;
            addr_d  = bus.redirect_pc;
          end
        end else if (bus.inst_valid) begin
          state_d = REQ;
          addr_d  = pc_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
    end
  end

  assign bus.inst_req  = (state_q != IDLE);
  assign bus.inst_addr = addr_q;
  assign bus.state     = state_q;

  fetch_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .flush     (bus.redirect),
    .push_pc   (addr_q),
    .push_inst (bus.inst_data),
    .out_valid (bus.out_valid),
    .out_pc    (bus.out_pc),
    .out_inst  (bus.out_inst),
    .count     (bus.fifo_count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand-written backpressure,
// wrap and reset sequences, then random traffic against a queue model.
module tb_fetch_unit;
  import core_pkg::*;

  localparam int          DW    = 32;
  localparam int          DEPTH = 4;
  localparam int          STEP  = 4;
  localparam logic [31:0] RPC   = 32'h0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) bus ();

  fetch_unit #(
    .DATA_WIDTH      (DW),
    .BYTE_DATA_WIDTH (STEP),
    .FIFO_DEPTH      (DEPTH),
    .RESET_PC        (RPC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [31:0] d, input logic r,
                       input logic [31:0] rp, input logic rdy);
    bus.inst_valid  = v;
    bus.inst_data   = d;
    bus.redirect    = r;
    bus.redirect_pc = rp;
    bus.out_ready   = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // ---------------- reference model ----------------
  logic [63:0] m_q[$];
  logic        m_inflight;
  logic        m_discard;
  logic [31:0] m_pc;
  logic [31:0] m_addr;

  task automatic model_reset();
    m_q.delete();
    m_inflight = 1'b0;
    m_discard  = 1'b0;
    m_pc       = RPC;
    m_addr     = RPC;
  endtask

  task automatic model_step(input logic v, input logic [31:0] d, input logic r,
                            input logic [31:0] rp, input logic rdy);
    logic do_pop;
    do_pop = (m_q.size() > 0) && rdy && !r;
    if (r) begin
      m_q.delete();
      m_pc = rp;
      if (m_inflight && !v) begin
        m_discard = 1'b1;
      end else begin
        m_inflight = 1'b1;
        m_discard  = 1'b0;
        m_addr     = rp;
      end
    end else begin
      if (do_pop) void'(m_q.pop_front());
      if (m_inflight && v) begin
        if (m_discard) begin
          m_discard = 1'b0;
          m_addr    = m_pc;
        end else begin
          m_q.push_back({m_addr, d});
          m_pc = m_pc + STEP;
          if (m_q.size() < DEPTH) m_addr = m_pc;
          else m_inflight = 1'b0;
        end
      end else if (!m_inflight && (m_q.size() < DEPTH)) begin
        m_inflight = 1'b1;
        m_addr     = m_pc;
      end
    end
  endtask

  task automatic model_compare(input int c);
    fetch_state_t exp_st;
    exp_st = !m_inflight ? IDLE : (m_discard ? KILL : REQ);
    check($sformatf("rnd%0d_req", c), 64'(bus.inst_req), 64'(m_inflight));
    check($sformatf("rnd%0d_state", c), 64'(bus.state), 64'(exp_st));
    check($sformatf("rnd%0d_count", c), 64'(bus.fifo_count), 64'(m_q.size()));
    check($sformatf("rnd%0d_ovalid", c), 64'(bus.out_valid), 64'(m_q.size() > 0));
    if (m_inflight) check($sformatf("rnd%0d_addr", c), 64'(bus.inst_addr), 64'(m_addr));
    if (m_q.size() > 0) check($sformatf("rnd%0d_head", c), {bus.out_pc, bus.out_inst}, m_q[0]);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        r;
    logic [31:0] rp;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_ov;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    int          e_cnt;
  } vec_t;

  localparam int NV = 14;
  vec_t tbl [NV];

  logic [63:0] exp_q[$];

  initial begin
    // Inputs: valid, data, redirect, redirect_pc, ready | expected after edge.
    tbl[0]  = '{1'b0, 32'h0,         1'b0, 32'h0,   1'b1, 1'b1, 32'h0,   1'b0, 32'h0,   32'h0,         0};
    tbl[1]  = '{1'b1, 32'h1111_0000, 1'b0, 32'h0,   1'b1, 1'b1, 32'h4,   1'b1, 32'h0,   32'h1111_0000, 1};
    tbl[2]  = '{1'b1, 32'h1111_0001, 1'b0, 32'h0,   1'b1, 1'b1, 32'h8,   1'b1, 32'h4,   32'h1111_0001, 1};
    tbl[3]  = '{1'b1, 32'h1111_0002, 1'b0, 32'h0,   1'b0, 1'b1, 32'hC,   1'b1, 32'h4,   32'h1111_0001, 2};
    tbl[4]  = '{1'b0, 32'h0,         1'b0, 32'h0,   1'b0, 1'b1, 32'hC,   1'b1, 32'h4,   32'h1111_0001, 2};
    tbl[5]  = '{1'b0, 32'h0,         1'b1, 32'h100, 1'b0, 1'b1, 32'hC,   1'b0, 32'h0,   32'h0,         0};
    tbl[6]  = '{1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0,   1'b0, 1'b1, 32'h100, 1'b0, 32'h0,   32'h0,         0};
    tbl[7]  = '{1'b1, 32'h2222_0000, 1'b0, 32'h0,   1'b0, 1'b1, 32'h104, 1'b1, 32'h100, 32'h2222_0000, 1};
    tbl[8]  = '{1'b1, 32'hBAD0_BAD0, 1'b1, 32'h200, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0,   32'h0,         0};
    tbl[9]  = '{1'b1, 32'h3333_0000, 1'b0, 32'h0,   1'b0, 1'b1, 32'h204, 1'b1, 32'h200, 32'h3333_0000, 1};
    tbl[10] = '{1'b0, 32'h0,         1'b0, 32'h0,   1'b1, 1'b1, 32'h204, 1'b0, 32'h0,   32'h0,         0};
    tbl[11] = '{1'b0, 32'h0,         1'b1, 32'h300, 1'b0, 1'b1, 32'h204, 1'b0, 32'h0,   32'h0,         0};
    tbl[12] = '{1'b0, 32'h0,         1'b1, 32'h400, 1'b0, 1'b1, 32'h204, 1'b0, 32'h0,   32'h0,         0};
    tbl[13] = '{1'b1, 32'h5555_5555, 1'b0, 32'h0,   1'b0, 1'b1, 32'h400, 1'b0, 32'h0,   32'h0,         0};

    // Reset values, observed while reset is held.
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req",   64'(bus.inst_req),   64'(0));
    check("rst_addr",  64'(bus.inst_addr),  64'(RPC));
    check("rst_ovalid", 64'(bus.out_valid), 64'(0));
    check("rst_inst",  64'(bus.out_inst),   64'(0));
    check("rst_pc",    64'(bus.out_pc),     64'(0));
    check("rst_count", 64'(bus.fifo_count), 64'(0));
    check("rst_state", 64'(bus.state),      64'(IDLE));
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].r, tbl[i].rp, tbl[i].rdy);
      tick();
      check($sformatf("v%0d_req", i),    64'(bus.inst_req),   64'(tbl[i].e_req));
      check($sformatf("v%0d_addr", i),   64'(bus.inst_addr),  64'(tbl[i].e_addr));
      check($sformatf("v%0d_ovalid", i), 64'(bus.out_valid),  64'(tbl[i].e_ov));
      check($sformatf("v%0d_count", i),  64'(bus.fifo_count), 64'(tbl[i].e_cnt));
      if (tbl[i].e_ov) begin
        check($sformatf("v%0d_head", i), {bus.out_pc, bus.out_inst}, {tbl[i].e_pc, tbl[i].e_inst});
      end
    end

    // Backpressure: cache answers one cycle after each request, decode stalls.
    do_reset();
    begin
      int          n_req;
      logic [31:0] d;
      n_req = 0;
      exp_q.delete();
      for (int c = 0; c < 8; c++) begin
        d = $urandom;
        if (bus.inst_req) begin
          check($sformatf("bp_addr%0d", n_req), 64'(bus.inst_addr), 64'(n_req * STEP));
          exp_q.push_back({bus.inst_addr, d});
          n_req++;
        end
        drive(bus.inst_req, d, 1'b0, 32'h0, 1'b0);
        tick();
      end
      check("bp_nreq",  64'(n_req),          64'(4));
      check("bp_count", 64'(bus.fifo_count), 64'(4));
      check("bp_req",   64'(bus.inst_req),   64'(0));
      check("bp_head",  {bus.out_pc, bus.out_inst}, exp_q[0]);

      // One pop from full re-enables fetch in the same cycle.
      drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      tick();
      void'(exp_q.pop_front());
      check("pop1_count", 64'(bus.fifo_count), 64'(3));
      check("pop1_req",   64'(bus.inst_req),   64'(1));
      check("pop1_addr",  64'(bus.inst_addr),  64'(16));
      check("pop1_head",  {bus.out_pc, bus.out_inst}, exp_q[0]);

      // Response and pop together at occupancy 3; write pointer wraps.
      d = $urandom;
      exp_q.push_back({32'd16, d});
      drive(1'b1, d, 1'b0, 32'h0, 1'b1);
      tick();
      void'(exp_q.pop_front());
      check("sim_count", 64'(bus.fifo_count), 64'(3));
      check("sim_req",   64'(bus.inst_req),   64'(1));
      check("sim_addr",  64'(bus.inst_addr),  64'(20));
      check("sim_head",  {bus.out_pc, bus.out_inst}, exp_q[0]);

      for (int c = 0; c < 3; c++) begin
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        tick();
        void'(exp_q.pop_front());
        check($sformatf("drain%0d_count", c), 64'(bus.fifo_count), 64'(exp_q.size()));
        if (exp_q.size() > 0) check($sformatf("drain%0d_head", c), {bus.out_pc, bus.out_inst}, exp_q[0]);
        else check($sformatf("drain%0d_ovalid", c), 64'(bus.out_valid), 64'(0));
      end
      check("drain_addr", 64'(bus.inst_addr), 64'(20));
    end

    // Asynchronous reset while a request is outstanding; late response ignored.
    #3;
    rst = 1'b0;
    #1;
    check("mrst_req",   64'(bus.inst_req),   64'(0));
    check("mrst_count", 64'(bus.fifo_count), 64'(0));
    check("mrst_state", 64'(bus.state),      64'(IDLE));
    drive(1'b1, 32'hCAFE_F00D, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("mrst_req2",   64'(bus.inst_req),   64'(1));
    check("mrst_addr2",  64'(bus.inst_addr),  64'(RPC));
    check("mrst_count2", 64'(bus.fifo_count), 64'(0));

    // Random traffic against the queue model.
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      logic        v, r, rdy;
      logic [31:0] d, rp;
      v   = bus.inst_req ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 19) == 0);
      d   = $urandom;
      r   = ($urandom_range(0, 11) == 0);
      rp  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      rdy = ($urandom_range(0, 3) < ((c / 250) % 4));
      drive(v, d, r, rp, rdy);
      tick();
      model_step(v, d, r, rp, rdy);
      model_compare(c);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
